// File: rtl/flit_pkg.sv
// Shared flit field layout and arbiter state type used by the packetizers,
// the link arbiter and the depacketizer.
package flit_pkg;

   localparam int FLIT_W  = 48;
   localparam int CTRL_HI = 47;
   localparam int CTRL_LO = 32;
   localparam int CTRL_W  = CTRL_HI - CTRL_LO + 1;
   localparam int DATA_HI = 31;
   localparam int DATA_LO = 16;

   localparam logic [CTRL_W-1:0] TAIL_CODE = 16'hFFFF;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/flit_link_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first requester found scanning
// cyclically upward from ptr.
module rr_pick
   import flit_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               any_req
);

   logic [IDX_W-1:0] w_idx;

   // Scan from the far end back toward ptr so the last hit is the closest one.
   always_comb begin
      gnt_idx = '0;
      any_req = 1'b0;
      w_idx   = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         w_idx = IDX_W'((int'(ptr) + k) % NUM_SRC);
         if (req[w_idx]) begin
            gnt_idx = w_idx;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/flit_link_arbiter.sv
// Packet-atomic round-robin arbiter sharing one registered flit link between
// NUM_SRC sources, with a flit-count watchdog that forces release.
module flit_link_arbiter
   import flit_pkg::*;
#(
   parameter int                NUM_SRC       = 4,
   parameter int                FLIT_W        = flit_pkg::FLIT_W,
   parameter logic [CTRL_W-1:0] TAIL_CODE     = flit_pkg::TAIL_CODE,
   parameter int                MAX_PKT_FLITS = 16,
   localparam int               IDX_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*FLIT_W-1:0] src_flit,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic [FLIT_W-1:0]         link_flit,
   output logic                      link_valid,
   input  logic                      link_ready,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy,
   output logic                      pkt_abort
);

   arb_state_t          r_state;
   logic [IDX_W-1:0]    r_grant_id;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [7:0]          r_flit_cnt;
   logic [FLIT_W-1:0]   r_link_flit;
   logic                r_link_valid;
   logic                r_pkt_abort;

   logic [IDX_W-1:0]    w_pick_idx;
   logic                w_any_req;
   logic [IDX_W-1:0]    w_sel;
   logic                w_slot_free;
   logic                w_accept;
   logic [FLIT_W-1:0]   w_sel_flit;
   logic                w_is_tail;
   logic                w_wd_hit;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return (int'(idx) == NUM_SRC - 1) ? '0 : idx + 1'b1;
   endfunction

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req     (src_valid),
      .ptr     (r_rr_ptr),
      .gnt_idx (w_pick_idx),
      .any_req (w_any_req)
   );

   // While locked only the owner may be served, even if it has dropped valid.
   always_comb begin
      w_slot_free = !r_link_valid || link_ready;
      w_sel       = (r_state == LOCKED) ? r_grant_id : w_pick_idx;
      src_ready   = '0;
      if (!reset && (r_state == LOCKED || w_any_req)) begin
         src_ready[w_sel] = w_slot_free;
      end
      w_accept   = src_valid[w_sel] && src_ready[w_sel];
      w_sel_flit = src_flit[w_sel*FLIT_W +: FLIT_W];
      w_is_tail  = (w_sel_flit[FLIT_W-1 -: CTRL_W] == TAIL_CODE);
      w_wd_hit   = ((r_flit_cnt + 8'd1) == 8'(MAX_PKT_FLITS));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_grant_id   <= '0;
         r_rr_ptr     <= '0;
         r_flit_cnt   <= '0;
         r_link_flit  <= '0;
         r_link_valid <= 1'b0;
         r_pkt_abort  <= 1'b0;
      end else begin
         r_pkt_abort <= 1'b0;

         if (w_accept) begin
            r_link_flit  <= w_sel_flit;
            r_link_valid <= 1'b1;
         end else if (link_ready) begin
            r_link_valid <= 1'b0;
         end

         if (w_accept) begin
            if (r_state == IDLE) begin
               r_grant_id <= w_sel;
               if (w_is_tail) begin
                  r_rr_ptr <= next_idx(w_sel);
               end else begin
                  r_state    <= LOCKED;
                  r_flit_cnt <= 8'd1;
               end
            end else if (w_is_tail || w_wd_hit) begin
               // A watchdog release looks like a tail to the ring, plus the abort pulse.
               r_state     <= IDLE;
               r_rr_ptr    <= next_idx(r_grant_id);
               r_flit_cnt  <= '0;
               r_pkt_abort <= !w_is_tail;
            end else begin
               r_flit_cnt <= r_flit_cnt + 8'd1;
            end
         end
      end
   end

   assign link_flit  = r_link_flit;
   assign link_valid = r_link_valid;
   assign grant_id   = r_grant_id;
   assign busy       = (r_state == LOCKED);
   assign pkt_abort  = r_pkt_abort;

endmodule

// File: doc/flit_link_arbiter.md
Name: flit_link_arbiter

Overview:
Packet-atomic round-robin arbiter that shares one 48-bit flit link between NUM_SRC packetizer sources, feeding the single depacketizer stage.
Flit format is fixed:
- [47:32] control word; 16'hFFFF marks the tail flit.
- [31:16] payload.
- [15:0] sideband, passed through untouched.

Once a source wins the link, it keeps it until its tail flit is accepted, so flits from different packets never interleave at the depacketizer. A flit-count watchdog forces release if a source never sends a tail.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- FLIT_W, 48, flit width; the control field is always the top 16 bits.
- TAIL_CODE, 16'hFFFF, control-word value identifying the tail flit.
- MAX_PKT_FLITS, 16, maximum flits per packet including the tail (2..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- src_valid  input  NUM_SRC  per-source flit valid.
- src_flit  input  NUM_SRC*FLIT_W  per-source flits; source i occupies bits [i*FLIT_W +: FLIT_W].
- src_ready  output  NUM_SRC  per-source accept; combinational.
- link_flit  output  FLIT_W  registered flit toward the depacketizer.
- link_valid  output  1  link_flit is valid.
- link_ready  input  1  downstream accepts link_flit this cycle.
- grant_id  output  clog2(NUM_SRC)  index of the source currently owning or last owning the link.
- busy  output  1  high while in LOCKED.
- pkt_abort  output  1  one-cycle pulse when the watchdog forces release.

Behaviour:
- Reset values (asynchronous): link_valid=0, link_flit=0, grant_id=0, busy=0, pkt_abort=0, state=IDLE, flit_cnt=0, rr_ptr=0 (source 0 highest priority after reset). src_ready=0 while reset is asserted.
- Output slot:
  - slot_free = !link_valid || link_ready.
  - A flit accepted from the owning source is loaded into link_flit and link_valid is set on the next edge. Latency is 1 cycle, with full throughput.
  - When link_valid=1 and link_ready=0, link_flit and link_valid hold stable.
  - When link_ready=1 and no new flit is accepted, link_valid clears.
- Accept: src_valid[i] && src_ready[i]. At most one src_ready bit is high in any cycle.
- Tail detection: flit[47:32]==TAIL_CODE.
- IDLE state:
  - Selection: winner = first i with src_valid[i], scanning cyclically from rr_ptr. src_ready[winner] = slot_free.
  - On accept with a non-tail flit: go to LOCKED, grant_id<=winner, flit_cnt<=1.
  - On accept with a tail flit (single-flit packet): stay in IDLE, grant_id<=winner, rr_ptr<=(winner+1) mod NUM_SRC.
  - No request, or slot not free: no change.
- LOCKED state:
  - src_ready[grant_id]=slot_free; all other src_ready bits are 0.
  - On accept with a tail flit: go to IDLE, rr_ptr<=(grant_id+1) mod NUM_SRC, flit_cnt<=0.
  - On accept with a non-tail flit and flit_cnt+1 == MAX_PKT_FLITS: the flit is forwarded unchanged. Then go to IDLE, pulse pkt_abort on the next cycle, and advance rr_ptr as for a tail.
  - Otherwise: flit_cnt<=flit_cnt+1.
  - The owner dropping src_valid mid-packet is legal. Ownership is kept and no other source is served.
- busy = (state==LOCKED).
- flit_cnt width is 8 bits. It never wraps, because the watchdog fires first.
- Backpressure: link_ready low for any number of cycles stalls the owner and never causes a grant change.
- Reset mid-packet: all state clears immediately and the in-flight link_flit is discarded. No synthetic tail is emitted; downstream shares the same reset.

Decomposition:
- Shared package flit_pkg holds:
  - FLIT_W=48
  - CTRL_HI=47, CTRL_LO=32
  - DATA_HI=31, DATA_LO=16
  - TAIL_CODE=16'hFFFF
  - the arb_state_t enum {IDLE, LOCKED}

  The depacketizer and packetizers reuse these field constants.
- One sub-module, rr_pick: combinational rotating-priority encoder with inputs req[NUM_SRC] and ptr, and outputs gnt_idx and any_req.

Test Plan:
1. Source 0 sends a 3-flit packet (control words 0x0001, 0x0002, 0xFFFF) with link_ready=1. Required: flits appear on link_flit on cycles 1..3 after first accept; busy is high after the first accept and low after the tail; rr_ptr=1.
2. All 4 sources send single-flit tail packets simultaneously and continuously. Required: grant order 0,1,2,3,0 with one flit per cycle; busy stays 0.
3. Source 1 is mid-packet and source 2 raises valid. Required: src_ready[2]=0 until source 1's tail is accepted; source 2's first flit appears the cycle after source 1's tail.
4. link_ready held 0 for 5 cycles mid-packet. Required: link_flit and link_valid stay stable; src_ready is low for the owner; no grant change; the stream resumes when link_ready=1.
5. Source 3 streams 20 non-tail flits with MAX_PKT_FLITS=16. Required: exactly 16 flits are forwarded, pkt_abort pulses once, and source 0 is granted next if it is requesting.
6. Reset asserted mid-packet with link_valid=1. Required: link_valid=0, busy=0 and grant_id=0 immediately. After release, source 0 has priority.
